// File: rtl/slavefifo2b_pkg.sv
// Shared definitions for the FX3 Slave FIFO 2-bit interface blocks.
// The stream-in generator imports the socket and direction constants from here too.
package slavefifo2b_pkg;

    // Arbiter sequencer states
    typedef enum logic [3:0] {
        IDLE,
        SETTLE,
        WR_WAIT,
        WR_BURST,
        WR_PKTEND,
        RD_WAIT,
        RD_BURST,
        RD_DRAIN,
        TURN
    } state_t;

    // Direction currently owning the bus
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_IN   = 2'd1,
        DIR_OUT  = 2'd2
    } dir_t;

    // FX3 socket addresses driven on faddr
    localparam logic [1:0] SOCK_IN  = 2'b00;
    localparam logic [1:0] SOCK_OUT = 2'b11;

    // Width of the settle / drain / turnaround down-counter (delays are 1..7 cycles)
    localparam int CNT_W = 3;

endpackage

// File: rtl/slavefifo2b_rdlat_pipe.sv
// Valid pipeline matching the fixed FX3 read latency: o_dout is i_din delayed
// by DEPTH clock cycles. Asynchronous clear empties the pipeline so no stale
// read word is flagged after a reset.
module slavefifo2b_rdlat_pipe
#(
    parameter int DEPTH = 2
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_dout
);

    logic [DEPTH-1:0] r_shift;

    // Shift the read-strobe history one stage per clock; cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
        end else begin
            r_shift <= (r_shift << 1) | DEPTH'(i_din);
        end
    end

    assign o_dout = r_shift[DEPTH-1];

endmodule

// File: rtl/slavefifo2b_dir_arbiter.sv
// Direction arbiter / sequencer for the FX3 Slave FIFO 2-bit bus.
// Round-robins the shared 32-bit bus between the stream-in producer (socket 00)
// and the stream-out consumer (socket 11), inserting flag-settle time after a
// socket change and turnaround idle cycles whenever a transfer ends.
module slavefifo2b_dir_arbiter
    import slavefifo2b_pkg::*;
#(
    parameter int BURST_LEN = 4096,
    parameter int FLAG_LAT  = 3,
    parameter int TURN_CYC  = 2,
    parameter int RD_LAT    = 2
)(
    input  logic        clk_100,
    input  logic        reset_,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic        wr_last,
    input  logic        flaga_d,
    input  logic        flagb_d,
    output logic [1:0]  faddr,
    output logic        slcs_,
    output logic        slwr_,
    output logic        slrd_,
    output logic        sloe_,
    output logic        pktend_,
    output logic        wr_grant,
    output logic        rd_valid,
    output logic [15:0] burst_cnt,
    output logic [1:0]  dir
);

    // burst_cnt is 16 bits and the delay counter is CNT_W bits wide
    if (BURST_LEN < 1 || BURST_LEN > 65536) begin : g_burst_len_check
        $error("slavefifo2b_dir_arbiter: BURST_LEN must be in 1..65536");
    end
    if (FLAG_LAT < 1 || FLAG_LAT > 7 || TURN_CYC < 1 || TURN_CYC > 7 ||
        RD_LAT < 1 || RD_LAT > 7) begin : g_delay_check
        $error("slavefifo2b_dir_arbiter: FLAG_LAT, TURN_CYC and RD_LAT must be in 1..7");
    end

    localparam logic [15:0]      LAST_WORD = 16'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(FLAG_LAT);
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYC);
    localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(RD_LAT);

    state_t           r_state;
    logic [1:0]       r_faddr;
    logic             r_slcs_n;
    logic             r_slwr_n;
    logic             r_slrd_n;
    logic             r_sloe_n;
    logic             r_pktend_n;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_burst_cnt;
    dir_t             r_dir;
    dir_t             r_last_dir;

    state_t           w_state_nx;
    logic [1:0]       w_faddr_nx;
    logic             w_slcs_nx;
    logic             w_slwr_nx;
    logic             w_slrd_nx;
    logic             w_sloe_nx;
    logic             w_pktend_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [15:0]      w_burst_nx;
    dir_t             w_dir_nx;
    dir_t             w_last_nx;
    logic             w_go_turn;
    logic             w_pick_in;
    logic             w_pick_out;
    logic             w_rd_valid;

    // Round-robin: on a tie the direction not served last wins
    assign w_pick_in  = wr_req && (!rd_req || (r_last_dir == DIR_OUT));
    assign w_pick_out = rd_req && !w_pick_in;

    // Read words arrive RD_LAT cycles after the strobe that requested them
    slavefifo2b_rdlat_pipe #(
        .DEPTH (RD_LAT)
    ) u_rdlat_pipe (
        .i_clk   (clk_100),
        .i_rst_n (reset_),
        .i_din   (!r_slrd_n),
        .o_dout  (w_rd_valid)
    );

    // Next-state and next registered-strobe decode; strobes default to released
    always_comb begin
        w_state_nx  = r_state;
        w_faddr_nx  = r_faddr;
        w_slcs_nx   = r_slcs_n;
        w_slwr_nx   = 1'b1;
        w_slrd_nx   = 1'b1;
        w_sloe_nx   = r_sloe_n;
        w_pktend_nx = 1'b1;
        w_cnt_nx    = r_cnt;
        w_burst_nx  = r_burst_cnt;
        w_dir_nx    = r_dir;
        w_last_nx   = r_last_dir;
        w_go_turn   = 1'b0;

        if (w_rd_valid) begin
            w_burst_nx = r_burst_cnt + 16'd1;
        end

        case (r_state)
            IDLE: begin
                if (w_pick_in || w_pick_out) begin
                    w_state_nx = SETTLE;
                    w_faddr_nx = w_pick_in ? SOCK_IN : SOCK_OUT;
                    w_dir_nx   = w_pick_in ? DIR_IN : DIR_OUT;
                    w_last_nx  = w_pick_in ? DIR_IN : DIR_OUT;
                    w_slcs_nx  = 1'b0;
                    w_cnt_nx   = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nx = (r_dir == DIR_IN) ? WR_WAIT : RD_WAIT;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            WR_WAIT: begin
                if (!wr_req) begin
                    w_go_turn = 1'b1;
                end else if (flagb_d) begin
                    w_state_nx = WR_BURST;
                    w_slwr_nx  = 1'b0;
                end
            end
            WR_BURST: begin
                if (!r_slwr_n) begin
                    w_burst_nx = r_burst_cnt + 16'd1;
                end
                if (!r_slwr_n && wr_last) begin
                    w_state_nx  = WR_PKTEND;
                    w_pktend_nx = 1'b0;
                end else if (!r_slwr_n && (r_burst_cnt == LAST_WORD)) begin
                    w_go_turn = 1'b1;
                end else if (flagb_d && wr_req) begin
                    w_slwr_nx = 1'b0;
                end else begin
                    w_go_turn = 1'b1;
                end
            end
            WR_PKTEND: begin
                w_go_turn = 1'b1;
            end
            RD_WAIT: begin
                if (!rd_req) begin
                    w_go_turn = 1'b1;
                end else if (flaga_d) begin
                    w_state_nx = RD_BURST;
                    w_sloe_nx  = 1'b0;
                    w_slrd_nx  = 1'b0;
                end
            end
            RD_BURST: begin
                if (flaga_d && rd_req) begin
                    w_slrd_nx = 1'b0;
                end else begin
                    w_state_nx = RD_DRAIN;
                    w_cnt_nx   = DRAIN_LD;
                end
            end
            RD_DRAIN: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_go_turn = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            TURN: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                    w_burst_nx = '0;
                    w_dir_nx   = DIR_NONE;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        if (w_go_turn) begin
            w_state_nx = TURN;
            w_slcs_nx  = 1'b1;
            w_sloe_nx  = 1'b1;
            w_cnt_nx   = TURN_LD;
        end
    end

    // State and strobe registers; an async reset drops any in-flight transfer
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            r_state     <= IDLE;
            r_faddr     <= SOCK_IN;
            r_slcs_n    <= 1'b1;
            r_slwr_n    <= 1'b1;
            r_slrd_n    <= 1'b1;
            r_sloe_n    <= 1'b1;
            r_pktend_n  <= 1'b1;
            r_cnt       <= '0;
            r_burst_cnt <= '0;
            r_dir       <= DIR_NONE;
            r_last_dir  <= DIR_OUT;
        end else begin
            r_state     <= w_state_nx;
            r_faddr     <= w_faddr_nx;
            r_slcs_n    <= w_slcs_nx;
            r_slwr_n    <= w_slwr_nx;
            r_slrd_n    <= w_slrd_nx;
            r_sloe_n    <= w_sloe_nx;
            r_pktend_n  <= w_pktend_nx;
            r_cnt       <= w_cnt_nx;
            r_burst_cnt <= w_burst_nx;
            r_dir       <= w_dir_nx;
            r_last_dir  <= w_last_nx;
        end
    end

    assign faddr     = r_faddr;
    assign slcs_     = r_slcs_n;
    assign slwr_     = r_slwr_n;
    assign slrd_     = r_slrd_n;
    assign sloe_     = r_sloe_n;
    assign pktend_   = r_pktend_n;
    assign wr_grant  = !r_slwr_n;
    assign rd_valid  = w_rd_valid;
    assign burst_cnt = r_burst_cnt;
    assign dir       = r_dir;

endmodule

// File: tb/tb_slavefifo2b_dir_arbiter.sv
// Directed self-checking bench for slavefifo2b_dir_arbiter (BURST_LEN=16).
module tb_slavefifo2b_dir_arbiter;
    import slavefifo2b_pkg::*;

    localparam int BL = 16;
    localparam int FL = 3;

    logic        clk_100 = 1'b0;
    logic        reset_  = 1'b1;
    logic        wr_req  = 1'b0;
    logic        rd_req  = 1'b0;
    logic        wr_last = 1'b0;
    logic        flaga_d = 1'b0;
    logic        flagb_d = 1'b0;
    logic [1:0]  faddr;
    logic        slcs_;
    logic        slwr_;
    logic        slrd_;
    logic        sloe_;
    logic        pktend_;
    logic        wr_grant;
    logic        rd_valid;
    logic [15:0] burst_cnt;
    logic [1:0]  dir;

    int testCount = 0;
    int failCount = 0;
    int exclViol  = 0;

    bit         monOn    = 1'b0;
    logic [1:0] lastSeen = 2'b00;
    logic [11:0] dirSeq  = 12'h000;
    int         seqLen   = 0;

    slavefifo2b_dir_arbiter #(
        .BURST_LEN (BL),
        .FLAG_LAT  (FL),
        .TURN_CYC  (2),
        .RD_LAT    (2)
    ) dut (
        .clk_100   (clk_100),
        .reset_    (reset_),
        .wr_req    (wr_req),
        .rd_req    (rd_req),
        .wr_last   (wr_last),
        .flaga_d   (flaga_d),
        .flagb_d   (flagb_d),
        .faddr     (faddr),
        .slcs_     (slcs_),
        .slwr_     (slwr_),
        .slrd_     (slrd_),
        .sloe_     (sloe_),
        .pktend_   (pktend_),
        .wr_grant  (wr_grant),
        .rd_valid  (rd_valid),
        .burst_cnt (burst_cnt),
        .dir       (dir)
    );

    // 100 MHz clock
    always #5 clk_100 = ~clk_100;

    // Bus ownership monitor: mutual exclusion every cycle, direction history on demand
    always @(negedge clk_100) begin
        if ((!slwr_ && !sloe_) || (!slwr_ && !slrd_)) begin
            exclViol++;
        end
        if (monOn && (dir !== lastSeen)) begin
            dirSeq   = {dirSeq[9:0], dir};
            seqLen++;
            lastSeen = dir;
        end
    end

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic r, input logic l,
                                 input logic fa, input logic fb);
        wr_req  = w;
        rd_req  = r;
        wr_last = l;
        flaga_d = fa;
        flagb_d = fb;
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_ = 1'b0;
        repeat (2) tick();
        reset_ = 1'b1;
    endtask

    task automatic waitDir(input logic [1:0] v, input int limit, input string tag);
        int n = 0;
        while (dir !== v && n < limit) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(dir), 32'(v));
    endtask

    initial begin
        int lowCount;
        logic [6:0] rdLow;
        logic [6:0] oeLow;
        logic [6:0] vld;

        // Reset values, observed without any clock edge
        #1 reset_ = 1'b0;
        #2;
        checkOutput("rst_faddr", 32'(faddr), 32'h0);
        checkOutput("rst_strobes", 32'({slcs_, slwr_, slrd_, sloe_, pktend_}), 32'h1F);
        checkOutput("rst_grant_valid", 32'({wr_grant, rd_valid}), 32'h0);
        checkOutput("rst_burst_cnt", 32'(burst_cnt), 32'h0);
        checkOutput("rst_dir", 32'(dir), 32'h0);

        // Solo write: 16-word burst, turnaround, re-arbitration
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("wr_grant_faddr", 32'(faddr), 32'h0);
        checkOutput("wr_grant_dir", 32'(dir), 32'h1);
        checkOutput("wr_grant_slcs", 32'(slcs_), 32'h0);
        repeat (FL) tick();
        checkOutput("wr_settle_slwr", 32'(slwr_), 32'h1);
        tick();
        checkOutput("wr_first_slwr", 32'(slwr_), 32'h0);
        checkOutput("wr_grant_eq", 32'(wr_grant), 32'h1);
        lowCount = 1;
        repeat (BL) begin
            tick();
            if (!slwr_) lowCount++;
        end
        checkOutput("wr_burst_words", 32'(lowCount), 32'(BL));
        checkOutput("wr_burst_end_slwr", 32'(slwr_), 32'h1);
        checkOutput("wr_burst_cnt", 32'(burst_cnt), 32'(BL));
        checkOutput("wr_turn_slcs", 32'(slcs_), 32'h1);
        tick();
        checkOutput("wr_turn2_slcs", 32'(slcs_), 32'h1);
        tick();
        checkOutput("wr_idle_dir", 32'(dir), 32'h0);
        checkOutput("wr_idle_cnt", 32'(burst_cnt), 32'h0);
        tick();
        checkOutput("wr_rearb_dir", 32'(dir), 32'h1);

        // Watermark stop after 5 writes
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (FL + 2) tick();
        checkOutput("wm_first_slwr", 32'(slwr_), 32'h0);
        repeat (4) tick();
        checkOutput("wm_fifth_slwr", 32'(slwr_), 32'h0);
        flagb_d = 1'b0;
        tick();
        checkOutput("wm_stop_slwr", 32'(slwr_), 32'h1);
        checkOutput("wm_burst_cnt", 32'(burst_cnt), 32'd5);
        checkOutput("wm_turn_slcs", 32'(slcs_), 32'h1);
        tick();
        checkOutput("wm_no_extra_grant", 32'(wr_grant), 32'h0);
        checkOutput("wm_cnt_hold", 32'(burst_cnt), 32'd5);

        // Short packet: wr_last on the third word
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (FL + 2) tick();
        repeat (2) tick();
        checkOutput("pk_third_slwr", 32'(slwr_), 32'h0);
        wr_last = 1'b1;
        tick();
        wr_last = 1'b0;
        checkOutput("pk_pktend", 32'({pktend_, slwr_, wr_grant}), 32'b010);
        checkOutput("pk_burst_cnt", 32'(burst_cnt), 32'd3);
        tick();
        checkOutput("pk_turn", 32'({pktend_, slwr_, slcs_}), 32'b111);

        // Solo read: four strobes, valids delayed by two, OE held through the drain
        applyReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("rd_grant_faddr", 32'(faddr), 32'h3);
        checkOutput("rd_grant_dir", 32'(dir), 32'h2);
        repeat (FL) tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            rdLow[6-i] = !slrd_;
            oeLow[6-i] = !sloe_;
            vld[6-i]   = rd_valid;
            if (i == 3) flaga_d = 1'b0;
        end
        checkOutput("rd_strobe_pattern", 32'(rdLow), 32'b1111000);
        checkOutput("rd_valid_pattern", 32'(vld), 32'b0011110);
        checkOutput("rd_oe_pattern", 32'(oeLow), 32'b1111110);
        checkOutput("rd_burst_cnt", 32'(burst_cnt), 32'd4);
        checkOutput("rd_turn_slcs", 32'(slcs_), 32'h1);

        // Both requesting from reset: in, turn, out, turn, in
        applyReset();
        lastSeen = dir;
        dirSeq   = 12'h000;
        seqLen   = 1;
        monOn    = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        waitDir(2'd2, 60, "rr_to_out");
        checkOutput("rr_out_faddr", 32'(faddr), 32'h3);
        repeat (6) tick();
        flaga_d = 1'b0;
        waitDir(2'd1, 40, "rr_back_in");
        checkOutput("rr_in_faddr", 32'(faddr), 32'h0);
        tick();
        monOn = 1'b0;
        checkOutput("rr_dir_seq", 32'(dirSeq), 32'h121);
        checkOutput("rr_dir_seq_len", 32'(seqLen), 32'd6);

        // Reset asserted mid read burst acts without a clock edge
        applyReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (FL + 5) tick();
        checkOutput("rr_pre_rst_busy", 32'({slrd_, sloe_, rd_valid}), 32'b001);
        #2 reset_ = 1'b0;
        #1;
        checkOutput("mrst_strobes", 32'({slcs_, slrd_, sloe_, rd_valid}), 32'b1110);
        checkOutput("mrst_state", 32'(dut.r_state), 32'(IDLE));
        checkOutput("mrst_dir_cnt", 32'({dir, burst_cnt}), 32'h0);
        tick();
        reset_ = 1'b1;
        tick();
        checkOutput("mrst_pipe_clear", 32'(rd_valid), 32'h0);

        checkOutput("mutex_invariant", 32'(exclViol), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/slavefifo2b_dir_arbiter.md
Name: slavefifo2b_dir_arbiter

Overview:
Direction arbiter and sequencer for the FX3 Slave FIFO 2-bit interface. It shares the single 32-bit bus between a stream-in producer (FPGA->host, socket address 2'b00) and a stream-out consumer (host->FPGA, socket address 2'b11). It drives faddr, slcs_, slwr_, slrd_, sloe_ and pktend_, and issues grants and valids to the datapath. It inserts bus-turnaround and flag-settle delays whenever the direction switches.

Parameters:
BURST_LEN, 4096, maximum words per write grant before the arbiter re-arbitrates.
FLAG_LAT, 3, cycles after a faddr change before flaga_d/flagb_d are treated as valid (range 1..7).
TURN_CYC, 2, idle cycles with sloe_=1 and slwr_=1 when the bus direction changes (range 1..7).
RD_LAT, 2, cycles from slrd_=0 to the corresponding word on the bus (fixed by the FX3 timing).

Ports:
clk_100  in  1  system clock, 100 MHz.
reset_  in  1  asynchronous, active-low reset.
wr_req  in  1  stream-in producer has data pending (level).
rd_req  in  1  stream-out consumer can accept data (level).
wr_last  in  1  producer marks the final word of a short packet; sampled when wr_grant=1.
flaga_d  in  1  registered FX3 full/empty flag for the current faddr; 1 = ready.
flagb_d  in  1  registered FX3 partial (watermark) flag; 1 = at least one more word is allowed.
faddr  out  2  FX3 socket address.
slcs_  out  1  chip select, active low.
slwr_  out  1  write strobe, active low.
slrd_  out  1  read strobe, active low.
sloe_  out  1  output enable, active low.
pktend_  out  1  packet-end strobe, active low.
wr_grant  out  1  producer must drive a word this cycle; always equals !slwr_.
rd_valid  out  1  the bus holds a valid read word this cycle.
burst_cnt  out  16  number of words transferred in the current grant.
dir  out  2  current direction: 0 = none, 1 = stream-in, 2 = stream-out.

Behaviour:
- Reset values: faddr=2'b00, slcs_=1, slwr_=1, slrd_=1, sloe_=1, pktend_=1, wr_grant=0, rd_valid=0, burst_cnt=0, dir=0, last_dir=stream-out (so stream-in wins the first tie). State is IDLE.
- Every strobe output is registered. wr_grant is combinational from the registered slwr_.
- Arbitration happens in IDLE only and is round-robin. If both requests are high, the direction opposite to last_dir wins; otherwise the single requester wins. If neither is high, the block stays in IDLE.
- States: IDLE, SETTLE, WR_WAIT, WR_BURST, WR_PKTEND, RD_WAIT, RD_BURST, RD_DRAIN, TURN.
- IDLE -> SETTLE on a grant. The grant loads faddr (00 or 11), dir and last_dir, sets slcs_=0 and loads the settle counter with FLAG_LAT.
- SETTLE counts down to 0, then goes to WR_WAIT or RD_WAIT. The flags are ignored while in SETTLE.
- WR_WAIT: when flagb_d=1 and wr_req=1, go to WR_BURST. If wr_req=0, go to TURN.
- WR_BURST: slwr_=0 while flagb_d=1 and wr_req=1. burst_cnt increments on every slwr_=0 cycle. Exit conditions:
  - wr_last=1 with slwr_=0: go to WR_PKTEND.
  - flagb_d=0 or wr_req=0: go to TURN.
  - burst_cnt reaches BURST_LEN-1 with slwr_=0: that word is written, then go to TURN.
- WR_PKTEND: pktend_=0 for exactly 1 cycle with slwr_=1, then go to TURN.
- RD_WAIT: when flaga_d=1 and rd_req=1, set sloe_=0 and go to RD_BURST. If rd_req=0, go to TURN.
- RD_BURST: slrd_=0 while flaga_d=1 and rd_req=1. A shift register of depth RD_LAT delays slrd_ to produce rd_valid, so rd_valid goes high exactly RD_LAT cycles after each slrd_=0 cycle. burst_cnt increments on each rd_valid. When flaga_d=0 or rd_req=0: slrd_=1, go to RD_DRAIN.
- RD_DRAIN: hold sloe_=0 for RD_LAT cycles so in-flight words still assert rd_valid. Then sloe_=1 and go to TURN.
- TURN: all strobes deasserted and slcs_=1 for TURN_CYC cycles. burst_cnt clears, dir returns to 0, then go to IDLE.
- Mutual exclusion is an invariant: slwr_ and sloe_ are never both 0, and slwr_ and slrd_ are never both 0.
- If a request drops mid-burst, the strobe deasserts on the next registered edge. No word is granted after the request is seen low.
- burst_cnt wraps modulo 2^16. BURST_LEN must be no greater than 65536, which is checked by an elaboration assertion.
- If reset_ is asserted mid-burst, all outputs return to their reset values immediately and asynchronously. The in-flight word is discarded and the rd_valid pipeline is cleared.

Decomposition:
- Shared package slavefifo2b_pkg: the state enum, dir encodings (DIR_NONE, DIR_IN, DIR_OUT) and socket constants (SOCK_IN=2'b00, SOCK_OUT=2'b11). The existing stream-in generator imports the same constants.
- One sub-module, slavefifo2b_rdlat_pipe: a parameterised RD_LAT-deep valid shift register with an asynchronous clear.

Test Plan:
- Solo write: wr_req=1, flagb_d=1, rd_req=0 -> faddr=00; slwr_ first goes low FLAG_LAT+1 cycles after the grant; with BURST_LEN=16 exactly 16 slwr_=0 cycles, then TURN for 2 cycles, then re-arbitration.
- Watermark stop: flagb_d falls after 5 writes -> slwr_ is high on the next edge; burst_cnt=5; TURN is entered; no extra wr_grant.
- Short packet: wr_last=1 on the 3rd word -> one pktend_=0 cycle with slwr_=1, then TURN.
- Solo read: rd_req=1, flaga_d high for 4 cycles -> 4 slrd_=0 cycles; rd_valid pulses are delayed by 2; sloe_ stays low until the last rd_valid; burst_cnt=4.
- Both requesting from reset -> order is stream-in, TURN, stream-out, TURN, stream-in; slwr_/sloe_ are never both low; dir follows 1, 0, 2, 0, 1.
- reset_ low during RD_BURST -> sloe_=1, slrd_=1, rd_valid=0 and state=IDLE without waiting for a clock edge.
